// File: rtl/macc_pkg.sv
// Shared sizing helpers and default operand widths for the MAC stream cores.
package macc_pkg;

  localparam int ADW_DEF = 24;
  localparam int BDW_DEF = 18;

  // Accumulator width that cannot overflow when summing nterms full-precision products.
  function automatic int macc_accw(input int adw, input int bdw, input int nterms);
    return adw + bdw + $clog2(nterms);
  endfunction

endpackage

// File: rtl/macc_mult_pipe.sv
// Two-stage registered signed multiplier: operand register, then full-precision product.
// Sideband last/valid travel with the data; everything holds while en_i is low.
module macc_mult_pipe import macc_pkg::*; #(
  parameter int ADW = ADW_DEF,
  parameter int BDW = BDW_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en_i,
  input  logic signed [ADW-1:0]     a_i,
  input  logic signed [BDW-1:0]     b_i,
  input  logic                      last_i,
  input  logic                      valid_i,
  output logic signed [ADW+BDW-1:0] p_o,
  output logic                      last_o,
  output logic                      valid_o
);

  localparam int PW = ADW + BDW;

  logic signed [ADW-1:0] a_q;
  logic signed [BDW-1:0] b_q;
  logic                  last1_q;
  logic                  valid1_q;
  logic signed [PW-1:0]  p_q;
  logic                  last2_q;
  logic                  valid2_q;

  // Operand capture and product stage, advancing together under the shared enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      last1_q  <= 1'b0;
      valid1_q <= 1'b0;
      p_q      <= '0;
      last2_q  <= 1'b0;
      valid2_q <= 1'b0;
    end else if (en_i) begin
      a_q      <= a_i;
      b_q      <= b_i;
      last1_q  <= last_i;
      valid1_q <= valid_i;
      p_q      <= PW'(a_q) * PW'(b_q);
      last2_q  <= last1_q;
      valid2_q <= valid1_q;
    end
  end

  assign p_o     = p_q;
  assign last_o  = last2_q;
  assign valid_o = valid2_q;

endmodule

// File: rtl/macc_axis.sv
// Streaming signed multiply-accumulate: joins operand streams A and B, sums A*B per
// packet (delimited by A's tlast) and emits one registered sum per packet.
module macc_axis import macc_pkg::*; #(
  parameter int ADW = ADW_DEF,
  parameter int BDW = BDW_DEF,
  parameter int ODW = macc_accw(ADW_DEF, BDW_DEF, 8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic signed [ADW-1:0] s_axis_atdata,
  input  logic                  s_axis_atvalid,
  output logic                  s_axis_atready,
  input  logic                  s_axis_atlast,
  input  logic signed [BDW-1:0] s_axis_btdata,
  input  logic                  s_axis_btvalid,
  output logic                  s_axis_btready,
  output logic signed [ODW-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);

  localparam int PW = ADW + BDW;

  if (ODW < PW) begin : g_odw_chk
    $error("macc_axis: ODW must be at least ADW+BDW");
  end

  logic                  en_s;
  logic                  ready_s;
  logic                  fire_s;
  logic signed [PW-1:0]  p_s;
  logic                  p_last_s;
  logic                  p_valid_s;
  logic signed [ODW-1:0] p_ext_s;
  logic signed [ODW-1:0] sum_s;

  logic signed [ODW-1:0] acc_q,    acc_d;
  logic                  first_q,  first_d;
  logic signed [ODW-1:0] tdata_q,  tdata_d;
  logic                  tvalid_q, tvalid_d;

  // A held output with no taker freezes the whole pipe, so nothing downstream is overwritten.
  assign en_s           = !(tvalid_q && !m_axis_tready);
  assign ready_s        = en_s && !rst;
  assign s_axis_atready = ready_s;
  assign s_axis_btready = ready_s;
  assign fire_s         = s_axis_atvalid && s_axis_btvalid && ready_s;

  macc_mult_pipe #(.ADW(ADW), .BDW(BDW)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .en_i    (en_s),
    .a_i     (s_axis_atdata),
    .b_i     (s_axis_btdata),
    .last_i  (s_axis_atlast),
    .valid_i (fire_s),
    .p_o     (p_s),
    .last_o  (p_last_s),
    .valid_o (p_valid_s)
  );

  assign p_ext_s = ODW'(p_s);
  assign sum_s   = (first_q ? '0 : acc_q) + p_ext_s;

  // Accumulate / emit next-state; with en high the old output is either taken or absent.
  always_comb begin
    acc_d    = acc_q;
    first_d  = first_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    if (en_s) begin
      tvalid_d = 1'b0;
      if (p_valid_s) begin
        if (p_last_s) begin
          tdata_d  = sum_s;
          tvalid_d = 1'b1;
          first_d  = 1'b1;
          acc_d    = '0;
        end else begin
          acc_d   = sum_s;
          first_d = 1'b0;
        end
      end else begin
        acc_d = acc_q;
      end
    end else begin
      tvalid_d = tvalid_q;
    end
  end

  // Accumulator and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      first_q  <= 1'b1;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      first_q  <= first_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;

endmodule
